// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//
// Shared constants and helpers for the digital clock datapath.
//
//   HOUR_MODULUS  default number of hour states (24-hour day)
//   HOUR_WIDTH    width of an hour count for the default modulus
//   BCD_W         width of one BCD display digit
//   to_bcd2()     binary 0..99 -> {tens, ones} packed BCD pair
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int HOUR_MODULUS = 24;
    localparam int HOUR_WIDTH   = 5;
    localparam int BCD_W        = 4;

    // Values above 99 are outside the display range. The tens digit still
    // fits in BCD_W bits for any 7-bit input, so no clamping is needed.
    function automatic logic [2*BCD_W-1:0] to_bcd2(input logic [6:0] bin);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = bin / 7'd10;
        ones = bin - (tens * 7'd10);
        return {tens[BCD_W-1:0], ones[BCD_W-1:0]};
    endfunction

endpackage : clock_pkg

// File: rtl/hour_display.sv
// -----------------------------------------------------------------------------
// hour_display
//
// Combinational display formatter for the hour count. Turns the binary hour
// into two BCD digits, in either 24-hour or 12-hour form, plus a PM flag.
//
// Parameters:
//   MODULUS   number of hour states of the counter feeding this block
//   WIDTH     width of the hour input (at most 7 bits)
//
// Ports:
//   hour_i      in   WIDTH  binary hour count
//   mode_12h_i  in   1      1 = 12-hour display, 0 = 24-hour display
//   bcd_tens_o  out  4      tens digit
//   bcd_ones_o  out  4      ones digit
//   pm_o        out  1      afternoon flag, 12-hour mode only
// -----------------------------------------------------------------------------
module hour_display
    import clock_pkg::*;
#(
    parameter int MODULUS = HOUR_MODULUS,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic [WIDTH-1:0] hour_i,
    input  logic             mode_12h_i,
    output logic [BCD_W-1:0] bcd_tens_o,
    output logic [BCD_W-1:0] bcd_ones_o,
    output logic             pm_o
);

    // 12-hour formatting only makes sense for a 24-state day. For any other
    // modulus the mode input is ignored and the plain count is shown.
    localparam bit TWELVE_OK = (MODULUS == 24);

    logic [6:0]         hour_ext;
    logic [6:0]         shown;
    logic               is_pm;
    logic [2*BCD_W-1:0] bcd;

    always_comb begin
        hour_ext              = '0;
        hour_ext[WIDTH-1:0]   = hour_i;
        shown                 = hour_ext;
        is_pm                 = 1'b0;

        if (TWELVE_OK && mode_12h_i) begin
            is_pm = (hour_ext >= 7'd12);
            shown = is_pm ? (hour_ext - 7'd12) : hour_ext;
            // Midnight and noon both read as 12 on a 12-hour face.
            if (shown == 7'd0) begin
                shown = 7'd12;
            end
        end

        bcd        = to_bcd2(shown);
        bcd_tens_o = bcd[2*BCD_W-1:BCD_W];
        bcd_ones_o = bcd[BCD_W-1:0];
        pm_o       = is_pm;
    end

endmodule : hour_display

// File: rtl/hour_counter.sv
// -----------------------------------------------------------------------------
// hour_counter
//
// Parametrised hour-of-day counter. Advances on a one-cycle tick from the
// minute stage, supports range-checked parallel load and manual up/down
// adjust, and drives BCD display digits in 12- or 24-hour form.
//
// Parameters:
//   MODULUS   number of hour states, count runs 0..MODULUS-1 (2..99)
//   WIDTH     count / load / bus width
//
// Ports:
//   clk       in   1      rising-edge clock
//   clear_n   in   1      synchronous active-low clear
//   tick      in   1      advance one hour (minute-stage carry)
//   load      in   1      parallel load strobe
//   data      in   WIDTH  load value
//   inc       in   1      manual adjust up
//   dec       in   1      manual adjust down
//   mode_12h  in   1      display format select
//   enable    in   1      databus output enable
//   hour      out  WIDTH  registered count
//   databus   out  WIDTH  hour when enabled, else zero
//   bcd_tens  out  4      display tens digit
//   bcd_ones  out  4      display ones digit
//   pm        out  1      afternoon flag in 12-hour mode
//   carry     out  1      one-cycle pulse on a tick-driven wrap
//   load_err  out  1      one-cycle pulse on an out-of-range load
//
// Update priority each cycle: clear, load, adjust, tick, hold. A lower
// priority request in the same cycle as a higher one is discarded, not
// deferred.
// -----------------------------------------------------------------------------
module hour_counter
    import clock_pkg::*;
#(
    parameter int MODULUS = HOUR_MODULUS,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             inc,
    input  logic             dec,
    input  logic             mode_12h,
    input  logic             enable,
    output logic [WIDTH-1:0] hour,
    output logic [WIDTH-1:0] databus,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             pm,
    output logic             carry,
    output logic             load_err
);

    // One extra bit so hour+1 at the top of the range is representable
    // before it is compared against the modulus.
    localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST_X = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] hour_q,     hour_d;
    logic             carry_q,    carry_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH:0]   hour_ext;
    logic [WIDTH:0]   hour_up;
    logic [WIDTH-1:0] hour_next_up;
    logic [WIDTH-1:0] hour_next_dn;
    logic             data_ok;

    // -------------------------------------------------------------------------
    // Step arithmetic shared by tick and manual adjust.
    // -------------------------------------------------------------------------
    always_comb begin
        hour_ext     = {1'b0, hour_q};
        hour_up      = hour_ext + 1'b1;
        hour_next_up = (hour_up == MOD_X) ? '0 : hour_up[WIDTH-1:0];
        hour_next_dn = (hour_q == '0) ? LAST_X[WIDTH-1:0] : (hour_q - 1'b1);
        data_ok      = ({1'b0, data} < MOD_X);
    end

    // -------------------------------------------------------------------------
    // Priority mux for the next count and the two status pulses. The pulses
    // default low every cycle, so they can never stretch beyond one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        hour_d     = hour_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            if (data_ok) begin
                hour_d = data;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc || dec) begin
            // Both pressed cancel out; any tick this cycle is dropped too.
            if (inc && !dec) begin
                hour_d = hour_next_up;
            end else if (dec && !inc) begin
                hour_d = hour_next_dn;
            end
        end else if (tick) begin
            hour_d  = hour_next_up;
            carry_d = (hour_ext == LAST_X);
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            hour_q     <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            hour_q     <= hour_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    assign hour     = hour_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;
    assign databus  = enable ? hour_q : '0;

    hour_display #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_display (
        .hour_i     (hour_q),
        .mode_12h_i (mode_12h),
        .bcd_tens_o (bcd_tens),
        .bcd_ones_o (bcd_ones),
        .pm_o       (pm)
    );

endmodule : hour_counter

// File: doc/hour_counter.md
# hour_counter

Parametrised hour-of-day counter for the digital clock datapath. It replaces the fixed 24-hour counter. It advances on a one-cycle tick from the minute stage and supports parallel load with range checking, up/down manual adjust, and a 12/24-hour display mode. It emits a day-rollover carry for the date/calendar stage and a gated data bus for the shared display bus.

## Interface
Parameters:
- MODULUS, 24: number of hour states; the count runs 0..MODULUS-1. Legal range is 2..99. 12-hour display requires MODULUS = 24.
- WIDTH, $clog2(MODULUS): width of the count, load data and bus.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clear_n  in  1  synchronous active-low reset.
- tick  in  1  one-cycle advance request, from the minute-stage carry.
- load  in  1  parallel-load strobe.
- data  in  WIDTH  load value, binary.
- inc  in  1  manual adjust up, one step per asserted cycle.
- dec  in  1  manual adjust down, one step per asserted cycle.
- mode_12h  in  1  display format: 1 = 12-hour, 0 = 24-hour. Affects display outputs only.
- enable  in  1  output enable for databus.
- hour  out  WIDTH  registered binary count.
- databus  out  WIDTH  equals hour when enable = 1, else all zeros. Combinational.
- bcd_tens  out  4  display tens digit.
- bcd_ones  out  4  display ones digit.
- pm  out  1  1 when hour >= 12 and mode_12h = 1, else 0.
- carry  out  1  registered one-cycle pulse on tick-driven wrap.
- load_err  out  1  registered one-cycle pulse on a rejected load.

## Operation
- Per-cycle priority for updating hour:
  1. clear_n = 0
  2. load
  3. inc/dec
  4. tick
  5. hold
- Reset: hour = 0, carry = 0, load_err = 0.
- Load with data < MODULUS: hour <= data. Load with data >= MODULUS: hour is unchanged and load_err pulses.
- Any load that cycle drops tick and adjust, and carry stays 0.
- inc alone: hour <= (hour+1) mod MODULUS. dec alone: hour <= hour = 0 ? MODULUS-1 : hour-1.
- inc and dec together: no change. Adjust wraps never assert carry. A tick during adjust is dropped.
- tick: hour <= (hour+1) mod MODULUS. carry = 1 on the next cycle only when hour was MODULUS-1.
- Display, 24-hour mode: digits are the BCD split of hour.
- Display, 12-hour mode: shown value is hour mod 12, with 0 shown as 12. Examples: hour 0 gives 1,2 and pm 0; hour 13 gives 0,1 and pm 1; hour 12 gives 1,2 and pm 1.
- Arithmetic is done at WIDTH+1 bits so the increment cannot overflow before the compare.

## Timing
- hour, carry and load_err update on the rising clk edge following the qualifying input. Latency is 1 cycle.
- bcd_tens, bcd_ones, pm and databus are combinational from hour and mode_12h, so they are valid in the same cycle as hour. Changing mode_12h updates the digits with no clock latency.
- Reset values, all outputs: hour 0, carry 0, load_err 0, databus 0, pm 0. Digits are 0,0 in 24-hour mode and 1,2 in 12-hour mode.
- clear_n low on the same edge as tick at hour MODULUS-1: reset wins and carry stays 0.
- Back-to-back ticks advance one step per cycle. carry pulses exactly once per wrap.
- carry and load_err are never held longer than one cycle.

## Structure
- Shared package clock_pkg holds:
  - HOUR_MODULUS = 24 and HOUR_WIDTH = 5
  - the BCD digit width constant
  - function to_bcd2 (binary 0..99 to two BCD digits)
- Sub-module hour_display (combinational): hour and mode_12h in; bcd_tens, bcd_ones and pm out.
- The top level holds the count register, the priority mux and the pulse registers.

## Test plan
- Reset, then 24 ticks with MODULUS = 24: hour goes 0..23, returns to 0, carry pulses once on the cycle after the 24th tick.
- Load data = 17 -> hour 17, digits 1,7. Load data = 25 -> hour stays 17, load_err pulses for one cycle.
- hour 0, dec -> 23 with carry 0. hour 23, inc -> 0 with carry 0. inc and dec together -> no change.
- mode_12h = 1 sweep: hour 0 -> 1,2, pm 0; hour 11 -> 1,1, pm 0; hour 12 -> 1,2, pm 1; hour 23 -> 1,1, pm 1.
- hour 23 with tick and clear_n = 0 together -> hour 0, carry 0. tick and load = 5 together -> hour 5, carry 0.
- MODULUS = 60 build: 60 ticks wrap to 0 with one carry. enable = 0 forces databus to 0 while hour keeps advancing.
